// File: rtl/bcp_pkg.sv
// Shared BCP definitions: literal encoding, conflict source codes and the queue FSM states.
package bcp_pkg;
  localparam int LIT_INDEX_MAX = 1024;
  localparam int CLA_LENGTH = 8;
  localparam int LIT_W = $clog2(LIT_INDEX_MAX) + 1;

  typedef logic signed [LIT_W-1:0] lit_t;

  typedef enum logic [1:0] {
    CS_NONE   = 2'd0,
    CS_CLAUSE = 2'd1,
    CS_CONTRA = 2'd2
  } conflict_src_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;
endpackage

// File: rtl/bcp_lit_cam_fifo.sv
// Circular literal buffer with per-entry valid bits and a one-cycle CAM probe
// that reports whether the probe literal or its negation is queued.
module bcp_lit_cam_fifo #(
  parameter int DEPTH = 16,
  parameter int LIT_W = 11,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [LIT_W-1:0] push_lit,
  input  logic             pop,
  input  logic [LIT_W-1:0] probe,
  output logic             match_pos,
  output logic             match_neg,
  output logic [LIT_W-1:0] head,
  output logic [CNT_W-1:0] count
);
  logic [LIT_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic [LIT_W-1:0] probe_neg;

  assign probe_neg = -probe;
  assign count     = cnt;
  assign head      = vld[rd_ptr] ? mem[rd_ptr] : '0;

  // Compares against every entry valid at the start of the cycle, including the head being popped.
  always_comb begin
    match_pos = 1'b0;
    match_neg = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (mem[i] == probe))     match_pos = 1'b1;
      if (vld[i] && (mem[i] == probe_neg)) match_neg = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      vld    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + 1'b1;
      end
      if (push) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Data storage carries no reset; entries are only observed through their valid bit.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_lit;
  end
endmodule

// File: rtl/bcp_imply_queue.sv
// Implication queue behind the BCP PE: deduplicates unit implications, queues them
// for broadcast, and halts on a clause conflict or a contradictory implication.
module bcp_imply_queue import bcp_pkg::*; #(
  parameter int LIT_INDEX_MAX = bcp_pkg::LIT_INDEX_MAX,
  parameter int DEPTH = 16,
  localparam int LIT_W = $clog2(LIT_INDEX_MAX) + 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_imply,
  input  logic [LIT_W-1:0] in_imply_idx,
  input  logic             in_done,
  input  logic             in_conflict,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LIT_W-1:0] out_lit,
  output logic             conflict,
  output logic [1:0]       conflict_src,
  output logic [CNT_W-1:0] count,
  output logic [15:0]      sat_cnt
);
  // Handshakes: a transfer happens on a cycle where valid && ready are both high at the
  // rising edge; ready never depends on the partner's valid, and flush voids both sides.

  state_e        state, state_nxt;
  conflict_src_e src_q, src_nxt;

  logic accept;
  logic pop;
  logic has_lit;
  logic match_pos;
  logic match_neg;
  logic beat_clause;
  logic beat_contra;
  logic beat_push;

  assign in_ready  = rst_n && (state == ST_RUN) && (count < CNT_W'(DEPTH)) && !flush;
  assign out_valid = (state == ST_RUN) && (count != '0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;

  // Literal 0 is reserved, so an implication of 0 carries no information.
  assign has_lit     = accept && !in_conflict && in_imply && (in_imply_idx != '0);
  assign beat_clause = accept && in_conflict;
  assign beat_contra = has_lit && match_neg;
  assign beat_push   = has_lit && !match_neg && !match_pos;

  bcp_lit_cam_fifo #(
    .DEPTH (DEPTH),
    .LIT_W (LIT_W)
  ) u_cam_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (flush),
    .push      (beat_push),
    .push_lit  (in_imply_idx),
    .pop       (pop),
    .probe     (in_imply_idx),
    .match_pos (match_pos),
    .match_neg (match_neg),
    .head      (out_lit),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_RUN;
      src_q <= CS_NONE;
    end else begin
      state <= state_nxt;
      src_q <= src_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    src_nxt   = src_q;
    if (flush) begin
      state_nxt = ST_RUN;
      src_nxt   = CS_NONE;
    end else if (state == ST_RUN) begin
      if (beat_clause) begin
        state_nxt = ST_HALT;
        src_nxt   = CS_CLAUSE;
      end else if (beat_contra) begin
        state_nxt = ST_HALT;
        src_nxt   = CS_CONTRA;
      end
    end
  end

  // HALT is only ever entered alongside a recorded conflict.
  assign conflict     = (state == ST_HALT);
  assign conflict_src = src_q;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      sat_cnt <= '0;
    end else if (accept && in_done && (sat_cnt != 16'hFFFF)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_bcp_imply_queue.sv
// Bench for bcp_imply_queue: directed scenarios plus random traffic against a queue-based model.
module tb_bcp_imply_queue;
  localparam int DEPTH = 16;
  localparam int LIT_W = 11;
  localparam int CNT_W = 5;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic             in_imply;
  logic [LIT_W-1:0] in_imply_idx;
  logic             in_done;
  logic             in_conflict;
  logic             out_valid;
  logic             out_ready;
  logic [LIT_W-1:0] out_lit;
  logic             conflict;
  logic [1:0]       conflict_src;
  logic [CNT_W-1:0] count;
  logic [15:0]      sat_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int q[$];
  bit m_halt;
  int m_src;
  int m_sat;

  bcp_imply_queue #(.LIT_INDEX_MAX(1024), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_imply     (in_imply),
    .in_imply_idx (in_imply_idx),
    .in_done      (in_done),
    .in_conflict  (in_conflict),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_lit      (out_lit),
    .conflict     (conflict),
    .conflict_src (conflict_src),
    .count        (count),
    .sat_cnt      (sat_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, $signed(got), $signed(exp), $time);
    end
  endtask

  function automatic bit q_has(input int v);
    foreach (q[i]) if (q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_ready();
    return rst_n && !flush && !m_halt && (q.size() < DEPTH);
  endfunction

  function automatic bit m_out_valid();
    return !m_halt && (q.size() != 0);
  endfunction

  task automatic check_all();
    int lit;
    lit = $signed(out_lit);
    check("in_ready", 32'(in_ready), 32'(m_ready()));
    check("out_valid", 32'(out_valid), 32'(m_out_valid()));
    check("out_lit", lit, (q.size() != 0) ? q[0] : 0);
    check("conflict", 32'(conflict), 32'(m_halt));
    check("conflict_src", 32'(conflict_src), m_src);
    check("count", 32'(count), q.size());
    check("sat_cnt", 32'(sat_cnt), m_sat);
  endtask

  // Advance the model across the coming rising edge using the inputs now applied.
  task automatic model_step();
    bit acc, pop, do_push;
    int lit;
    if (!rst_n || flush) begin
      q.delete();
      m_halt = 0;
      m_src = 0;
      m_sat = 0;
      return;
    end
    acc = in_valid && m_ready();
    pop = m_out_valid() && out_ready;
    do_push = 0;
    lit = $signed(in_imply_idx);
    if (acc) begin
      if (in_done && m_sat < 65535) m_sat++;
      if (in_conflict) begin
        m_halt = 1;
        m_src = 1;
      end else if (in_imply && lit != 0) begin
        if (q_has(-lit)) begin
          m_halt = 1;
          m_src = 2;
        end else if (!q_has(lit)) begin
          do_push = 1;
        end
      end
    end
    if (pop) void'(q.pop_front());
    if (do_push) q.push_back(lit);
  endtask

  // Driver: apply one cycle of inputs at the falling edge, check, then step the model.
  task automatic drive(input bit rst, input bit fl, input bit v, input bit imp, input int idx,
                       input bit dn, input bit cf, input bit ordy);
    @(negedge clk);
    rst_n        = rst;
    flush        = fl;
    in_valid     = v;
    in_imply     = imp;
    in_imply_idx = idx[LIT_W-1:0];
    in_done      = dn;
    in_conflict  = cf;
    out_ready    = ordy;
    #1;
    check_all();
    model_step();
  endtask

  task automatic push_lit(input int idx, input bit ordy);
    drive(1, 0, 1, 1, idx, 0, 0, ordy);
  endtask

  task automatic idle(input bit ordy);
    drive(1, 0, 0, 0, 0, 0, 0, ordy);
  endtask

  task automatic do_flush();
    drive(1, 1, 1, 1, 1, 1, 0, 1);
  endtask

  initial begin
    int v;
    rst_n = 0; flush = 0; in_valid = 0; in_imply = 0; in_imply_idx = '0;
    in_done = 0; in_conflict = 0; out_ready = 0;
    q.delete(); m_halt = 0; m_src = 0; m_sat = 0;
    repeat (2) @(posedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Three implications held, then drained in order
    push_lit(5, 0);
    push_lit(-7, 0);
    push_lit(12, 0);
    idle(0);
    repeat (4) idle(1);

    // Dedup then contradiction
    push_lit(9, 0);
    push_lit(9, 0);
    push_lit(-9, 0);
    repeat (2) idle(1);

    // Clause conflict wins over a simultaneous implication
    do_flush();
    drive(1, 0, 1, 1, 3, 0, 1, 0);
    idle(0);
    do_flush();
    idle(0);

    // Fill, one pop, then mixed traffic over several pointer wraps
    for (int i = 1; i <= DEPTH; i++) push_lit(i * 3, 0);
    idle(0);
    idle(1);
    idle(0);
    for (int i = 0; i < 3 * DEPTH; i++)
      drive(1, 0, $urandom_range(0, 3) != 0, 1, $urandom_range(100, 140), 0, 0,
            $urandom_range(0, 2) != 0);
    repeat (DEPTH + 2) idle(1);

    // Same-cycle pop of head and push of the same / negated literal
    do_flush();
    push_lit(4, 0);
    push_lit(4, 1);
    idle(0);
    push_lit(4, 0);
    push_lit(-4, 1);
    repeat (2) idle(1);

    // Random traffic with occasional flushes and clause conflicts
    do_flush();
    for (int i = 0; i < 600; i++) begin
      v = $urandom_range(0, 24) - 12;
      drive(1, $urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
            v, $urandom_range(0, 1), $urandom_range(0, 60) == 0, $urandom_range(0, 2) == 0);
    end

    // Saturating satisfied-clause counter
    do_flush();
    for (int i = 0; i < 70000; i++) drive(1, 0, 1, 0, 0, 1, 0, 0);
    idle(0);

    // Reset with the queue half full
    for (int i = 1; i <= DEPTH / 2; i++) push_lit(i + 20, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    idle(0);
    idle(0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
